// File: rtl/line_scaler_buffer.sv
// Line ring buffer with fixed-point horizontal resampling and repeat-last-line vertical upscaling.
// Optional macro LINE_SCALER_INTERP_EN selects two-tap linear interpolation (3-cycle latency).
module line_scaler_buffer #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned IN_MAX   = 1024,
  parameter int unsigned NUM_BUFS = 3,
  parameter int unsigned FRAC_W   = 16
) (
  input  logic                             clk_pixel,
  input  logic                             rst_n,
  input  logic                             wr_line_start,
  input  logic                             wr_valid,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             rd_line_start,
  input  logic                             rd_req,
  input  logic [$clog2(IN_MAX)+FRAC_W-1:0] h_step,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic [$clog2(IN_MAX):0]          line_len,
  output logic                             wr_trunc,
  output logic                             rd_repeat
);

  localparam int unsigned IDX_W = $clog2(IN_MAX);
  localparam int unsigned BUF_W = $clog2(NUM_BUFS);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned PH_W  = IDX_W + FRAC_W;
  localparam int unsigned DEPTH = NUM_BUFS * IN_MAX;

  logic [BUF_W-1:0]  wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, latest_q, latest_d;
  logic              latest_new_q, latest_new_d, any_commit_q, any_commit_d;
  logic              rd_has_line_q, rd_has_line_d;
  logic [LEN_W-1:0]  wr_count_q, wr_count_d;
  logic [LEN_W-1:0]  len_q [NUM_BUFS];
  logic [LEN_W-1:0]  len_d [NUM_BUFS];
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [LEN_W-1:0]  line_len_q, line_len_d;
  logic              wr_trunc_q, wr_trunc_d, rd_repeat_q, rd_repeat_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              vld1_q, vld1_d, ok1_q, ok1_d;

  logic              commit, latest_new_eff, wr_en, wr_found;
  logic [BUF_W-1:0]  wr_cand;
  logic [LEN_W-1:0]  wr_base, len_m1;
  logic [IDX_W-1:0]  wr_idx, idx_raw, rd_idx;

  always_comb begin
    commit         = wr_line_start && (wr_count_q != '0);
    latest_new_eff = commit || latest_new_q;
    latest_d       = commit ? wr_buf_q : latest_q;
    any_commit_d   = any_commit_q || commit;
    len_d          = len_q;
    if (commit) len_d[wr_buf_q] = wr_count_q;

    rd_buf_d      = rd_buf_q;
    latest_new_d  = latest_new_eff;
    rd_repeat_d   = 1'b0;
    rd_has_line_d = rd_has_line_q;
    line_len_d    = line_len_q;
    phase_d       = phase_q;
    if (rd_line_start) begin
      // A line committed in this same cycle is already visible to the reader.
      if (latest_new_eff) begin
        rd_buf_d      = latest_d;
        latest_new_d  = 1'b0;
        rd_has_line_d = 1'b1;
      end else begin
        rd_repeat_d = any_commit_q;
      end
      line_len_d = len_d[rd_buf_d];
      phase_d    = '0;
    end else if (rd_req) begin
      phase_d = phase_q + h_step;
    end

    wr_buf_d = wr_buf_q;
    wr_found = 1'b0;
    wr_cand  = '0;
    if (commit) begin
      for (int k = 1; k < int'(NUM_BUFS); k++) begin
        wr_cand = BUF_W'((int'(wr_buf_q) + k) % int'(NUM_BUFS));
        if (!wr_found && wr_cand != latest_d && wr_cand != rd_buf_d) begin
          wr_buf_d = wr_cand;
          wr_found = 1'b1;
        end
      end
    end

    wr_base    = wr_line_start ? '0 : wr_count_q;
    wr_en      = wr_valid && (wr_base < LEN_W'(IN_MAX));
    wr_idx     = wr_base[IDX_W-1:0];
    wr_count_d = wr_en ? wr_base + LEN_W'(1) : wr_base;
    wr_trunc_d = wr_trunc_q || (wr_valid && !wr_en);

    idx_raw = phase_q[FRAC_W +: IDX_W];
    len_m1  = line_len_q - LEN_W'(1);
    if (line_len_q == '0)            rd_idx = '0;
    else if ({1'b0, idx_raw} > len_m1) rd_idx = len_m1[IDX_W-1:0];
    else                             rd_idx = idx_raw;

    vld1_d = rd_req;
    ok1_d  = rd_has_line_q;
  end

`ifdef LINE_SCALER_INTERP_EN
  localparam int unsigned MW = DATA_W + 9;

  logic [DATA_W-1:0] mem_e [DEPTH/2];
  logic [DATA_W-1:0] mem_o [DEPTH/2];
  logic [DATA_W-1:0] ram_e_q, ram_o_q;
  logic [IDX_W-1:0]  rd_idx_b, e_idx, o_idx;
  logic              a_odd_q, a_odd_d, same_q, same_d;
  logic [7:0]        frac_q, frac_d;
  logic              vld2_q, vld2_d, ok2_q, ok2_d;
  logic [DATA_W-1:0] interp_q, interp_d, av, bv;
  logic signed [MW-1:0] a_s, b_s, prod_s, sum_s;

  always_comb begin
    if (line_len_q == '0 || ({1'b0, rd_idx} + LEN_W'(1)) > len_m1) rd_idx_b = rd_idx;
    else                                                           rd_idx_b = rd_idx + IDX_W'(1);
    e_idx   = rd_idx[0] ? rd_idx_b : rd_idx;
    o_idx   = rd_idx[0] ? rd_idx : rd_idx_b;
    a_odd_d = rd_idx[0];
    same_d  = (rd_idx_b == rd_idx);
    frac_d  = phase_q[FRAC_W-1 -: 8];

    av       = a_odd_q ? ram_o_q : ram_e_q;
    bv       = same_q ? av : (a_odd_q ? ram_e_q : ram_o_q);
    a_s      = $signed({9'b0, av});
    b_s      = $signed({9'b0, bv});
    prod_s   = (b_s - a_s) * $signed({{(DATA_W + 1){1'b0}}, frac_q});
    sum_s    = a_s + (prod_s >>> 8);
    interp_d = sum_s[DATA_W-1:0];
    vld2_d   = vld1_q;
    ok2_d    = ok1_q;

    rd_valid_d = vld2_q;
    rd_data_d  = vld2_q ? (ok2_q ? interp_q : '0) : rd_data_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en && !wr_idx[0]) mem_e[{wr_buf_d, wr_idx[IDX_W-1:1]}] <= wr_data;
    if (wr_en &&  wr_idx[0]) mem_o[{wr_buf_d, wr_idx[IDX_W-1:1]}] <= wr_data;
    ram_e_q <= mem_e[{rd_buf_q, e_idx[IDX_W-1:1]}];
    ram_o_q <= mem_o[{rd_buf_q, o_idx[IDX_W-1:1]}];
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      a_odd_q  <= 1'b0;
      same_q   <= 1'b0;
      frac_q   <= '0;
      vld2_q   <= 1'b0;
      ok2_q    <= 1'b0;
      interp_q <= '0;
    end else begin
      a_odd_q  <= a_odd_d;
      same_q   <= same_d;
      frac_q   <= frac_d;
      vld2_q   <= vld2_d;
      ok2_q    <= ok2_d;
      interp_q <= interp_d;
    end
  end
`else
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  always_comb begin
    rd_valid_d = vld1_q;
    rd_data_d  = vld1_q ? (ok1_q ? ram_rd_q : '0) : rd_data_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en) mem[{wr_buf_d, wr_idx}] <= wr_data;
    ram_rd_q <= mem[{rd_buf_q, rd_idx}];
  end
`endif

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      wr_buf_q      <= '0;
      rd_buf_q      <= BUF_W'(NUM_BUFS - 1);
      latest_q      <= '0;
      latest_new_q  <= 1'b0;
      any_commit_q  <= 1'b0;
      rd_has_line_q <= 1'b0;
      wr_count_q    <= '0;
      for (int i = 0; i < int'(NUM_BUFS); i++) len_q[i] <= '0;
      phase_q       <= '0;
      line_len_q    <= '0;
      wr_trunc_q    <= 1'b0;
      rd_repeat_q   <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      vld1_q        <= 1'b0;
      ok1_q         <= 1'b0;
    end else begin
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      latest_q      <= latest_d;
      latest_new_q  <= latest_new_d;
      any_commit_q  <= any_commit_d;
      rd_has_line_q <= rd_has_line_d;
      wr_count_q    <= wr_count_d;
      len_q         <= len_d;
      phase_q       <= phase_d;
      line_len_q    <= line_len_d;
      wr_trunc_q    <= wr_trunc_d;
      rd_repeat_q   <= rd_repeat_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      vld1_q        <= vld1_d;
      ok1_q         <= ok1_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign line_len  = line_len_q;
  assign wr_trunc  = wr_trunc_q;
  assign rd_repeat = rd_repeat_q;

endmodule

// File: tb/tb_line_scaler_buffer.sv
// Bench for line_scaler_buffer: directed and random lines checked against a line-level model.
module tb_line_scaler_buffer;
`ifdef LINE_SCALER_INTERP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int IN_MAX = 1024;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wls = 1'b0, wv = 1'b0, rls = 1'b0, rq = 1'b0;
  logic [11:0] wd = '0;
  logic [25:0] h_step = 26'h10000;
  logic [11:0] rd_data;
  logic        rd_valid, wr_trunc, rd_repeat;
  logic [10:0] line_len;

  always #5 clk = ~clk;

  line_scaler_buffer dut (
    .clk_pixel(clk), .rst_n(rst_n), .wr_line_start(wls), .wr_valid(wv), .wr_data(wd),
    .rd_line_start(rls), .rd_req(rq), .h_step(h_step), .rd_data(rd_data),
    .rd_valid(rd_valid), .line_len(line_len), .wr_trunc(wr_trunc), .rd_repeat(rd_repeat)
  );

  int checks = 0, failures = 0;

  // Model: whole lines as sample lists; the writer never disturbs the shown or latest line.
  int     cur[$], latest[$], shown[$];
  bit     latest_new, committed, m_trunc, m_repeat;
  int     m_len;
  longint phase;
  bit     pv[LAT];
  int     pd[LAT];

  function automatic int exp_pix(longint p);
    int l, a, b, f, idx;
    l = shown.size();
    if (l == 0) return 0;
    idx = int'(p >> 16);
    if (idx > l - 1) idx = l - 1;
    a = shown[idx];
`ifdef LINE_SCALER_INTERP_EN
    b = (idx + 1 > l - 1) ? shown[l - 1] : shown[idx + 1];
    f = int'((p >> 8) & 255);
    return (a + (((b - a) * f) >>> 8)) & 'hFFF;
`else
    b = 0;
    f = 0;
    return a + b * f;
`endif
  endfunction

  task automatic cyc(input bit i_wls, input bit i_wv, input int i_wd, input bit i_rls,
                     input bit i_rq);
    bit nv;
    int nd;
    wls = i_wls; wv = i_wv; wd = 12'(i_wd); rls = i_rls; rq = i_rq;
    nv = i_rq;
    nd = exp_pix(phase);
    if (!rst_n) begin
      cur.delete(); latest.delete(); shown.delete();
      latest_new = 0; committed = 0; m_trunc = 0; m_repeat = 0; m_len = 0; phase = 0;
    end else begin
      if (i_wls) begin
        if (cur.size() != 0) begin
          latest = cur; latest_new = 1; committed = 1;
        end
        cur.delete();
      end
      m_repeat = 0;
      if (i_rls) begin
        if (latest_new) begin
          shown = latest; latest_new = 0;
        end else begin
          m_repeat = committed;
        end
        m_len = shown.size();
        phase = 0;
      end else if (i_rq) begin
        phase = (phase + longint'(h_step)) % (longint'(1) << 26);
      end
      if (i_wv) begin
        if (cur.size() < IN_MAX) cur.push_back(i_wd & 'hFFF);
        else m_trunc = 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pd[i] = pd[i-1];
    end
    pv[0] = nv; pd[0] = nd;
    if (!rst_n) for (int i = 0; i < LAT; i++) pv[i] = 0;

    checks++;
    assert (rd_valid === pv[LAT-1]) else begin
      failures++;
      $error("FAIL rd_valid observed=%0b expected=%0b", rd_valid, pv[LAT-1]);
    end
    if (pv[LAT-1] || !rst_n) begin
      checks++;
      assert (rd_data === 12'(rst_n ? pd[LAT-1] : 0)) else begin
        failures++;
        $error("FAIL rd_data observed=%0d expected=%0d", rd_data, rst_n ? pd[LAT-1] : 0);
      end
    end
    checks++;
    assert (line_len === 11'(m_len)) else begin
      failures++;
      $error("FAIL line_len observed=%0d expected=%0d", line_len, m_len);
    end
    checks++;
    assert (wr_trunc === m_trunc) else begin
      failures++;
      $error("FAIL wr_trunc observed=%0b expected=%0b", wr_trunc, m_trunc);
    end
    checks++;
    assert (rd_repeat === m_repeat) else begin
      failures++;
      $error("FAIL rd_repeat observed=%0b expected=%0b", rd_repeat, m_repeat);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int v, n, len, wrote;
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = 0; end
    // Reset and reads before any line exists: zero data, valid follows rd_req.
    rst_n = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    flush();

    // 1:1 ramp copy
    for (int i = 0; i < 640; i++) cyc(0, 1, i, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    h_step = 26'h10000;
    for (int i = 0; i < 640; i++) cyc(0, 0, 0, 0, 1);
    flush();

    // 2x horizontal upscale of the same line, reads past the end hold the last sample
    h_step = 26'h08000;
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 1300; i++) cyc(0, 0, 0, 0, 1);
    flush();

    // Vertical repeat, then a fresh constant line
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1);
    end
    h_step = 26'h10000;
    for (int i = 0; i < 64; i++) cyc(0, 1, 'hABC, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 1);
    flush();

    // Truncation: 1100 samples, flag is sticky until reset
    for (int i = 0; i < 1100; i++) cyc(0, 1, i, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 1030; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 7 * i, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    flush();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    flush();

    // Simultaneous commit and read-select while writing continuously
    v = int'($urandom_range(0, 4095));
    for (int i = 0; i < 40; i++) cyc(0, 1, v, 0, 0);
    for (int l = 0; l < 10; l++) begin
      v = int'($urandom_range(0, 4095));
      cyc(1, 1, v, 1, 1);
      for (int i = 0; i < 39; i++) cyc(0, 1, v, 0, 1);
    end
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 1);
    flush();

    // Random lines, random step, gappy writes and reads
    for (int l = 0; l < 4; l++) begin
      len = int'($urandom_range(1, 300));
      wrote = 0;
      while (wrote < len) begin
        if ($urandom_range(0, 3) != 0) begin
          cyc(0, 1, int'($urandom_range(0, 4095)), 0, 0);
          wrote++;
        end else begin
          cyc(0, 0, 0, 0, 0);
        end
      end
      h_step = 26'($urandom_range(26'h2000, 26'h30000));
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      n = int'($urandom_range(50, 400));
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1'($urandom_range(0, 3) != 0));
      flush();
    end

    // Two-sample line at quarter step
    cyc(0, 1, 100, 0, 0);
    cyc(0, 1, 200, 0, 0);
    cyc(1, 0, 0, 0, 0);
    h_step = 26'h04000;
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_scaler_buffer.md
Name: line_scaler_buffer

Overview:
Parametrised successor to the fixed two-line ping-pong video buffer. Captures composite-sampled lines from the ADC/sync path into an N-entry line ring and reads them back on the HDMI pixel timeline. Horizontal resampling uses a programmable fixed-point step. Vertical upscaling repeats the newest complete line when no new one has arrived. Sits between sync_separator and the RGB formatter in the clk_pixel domain.

Parameters:
DATA_W, 12, sample width.
IN_MAX, 1024, max stored samples per input line (power of 2).
NUM_BUFS, 3, line buffers in ring; must be >=3.
FRAC_W, 16, fractional bits of h_step / phase.

Ports:
clk_pixel  in  1  sole clock.
rst_n  in  1  synchronous, active-low reset.
wr_line_start  in  1  one-cycle pulse at input h-sync; commits the line in progress.
wr_valid  in  1  sample qualifier (active video AND ADC strobe).
wr_data  in  DATA_W  ADC sample.
rd_line_start  in  1  one-cycle pulse at HDMI line start (cx==0).
rd_req  in  1  HDMI video_data_period; one output pixel per high cycle.
h_step  in  log2(IN_MAX)+FRAC_W  input samples advanced per output pixel; held static per line.
rd_data  out  DATA_W  resampled pixel.
rd_valid  out  1  rd_data qualifier.
line_len  out  log2(IN_MAX)+1  length of the line being read.
wr_trunc  out  1  sticky; line exceeded IN_MAX.
rd_repeat  out  1  one-cycle pulse; the line was re-displayed.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, line_len=0, wr_trunc=0, rd_repeat=0. wr_buf=0, rd_buf=NUM_BUFS-1, no line committed, wr_count=0, phase=0.
- Storage: inferred RAM, NUM_BUFS*IN_MAX words. Address = {buf, idx}. Registered read.
- Write: each wr_valid cycle with wr_count<IN_MAX writes wr_data at {wr_buf, wr_count}, then wr_count+1.
  - wr_valid at wr_count==IN_MAX: sample dropped, wr_trunc<=1 until reset.
- Commit on wr_line_start:
  - If wr_count!=0: len[wr_buf]<=wr_count, latest<=wr_buf, latest_new<=1.
  - wr_buf advances to the first index after it (mod NUM_BUFS) that differs from both the new latest and the post-update rd_buf.
  - wr_count<=0 in all cases. A zero-length line is discarded; wr_buf is unchanged.
  - wr_valid in the same cycle as wr_line_start belongs to the new line and is written at idx 0.
- Read line select on rd_line_start:
  - If latest_new: rd_buf<=latest, latest_new<=0.
  - Else, if any line has ever been committed: rd_buf is kept and rd_repeat pulses.
  - line_len<=len[rd_buf], phase<=0.
  - Simultaneous commit and rd_line_start: the reader takes the just-committed buffer, and the writer exclusion uses that value. The writer never targets rd_buf.
- Read datapath: each rd_req cycle:
  - idx = phase[MSBs], clamped to line_len-1.
  - Issue the RAM read, then phase += h_step (wraps modulo width; no saturation).
- Latency: rd_data/rd_valid appear 2 cycles after the rd_req cycle (RAM register + output register). rd_valid is rd_req delayed 2 cycles.
- Before the first commit: rd_data=0 while rd_valid follows rd_req.
- h_step=1<<FRAC_W gives 1:1 copy. Smaller values upscale horizontally.
- Reset mid-line: all state returns to reset values. RAM contents are don't-care. The first output after reset is zero until a commit occurs.

Optional Feature:
LINE_SCALER_INTERP_EN
- Defined: the RAM is split into even/odd banks so samples idx and idx+1 (idx+1 clamped to line_len-1) are read in the same cycle.
  - f = top 8 bits of the phase fraction.
  - rd_data = a + (((b-a)*f) >>> 8), computed signed in DATA_W+9 bits, truncated.
  - Latency becomes 3 cycles; rd_valid delay matches.
- Undefined: nearest-neighbour (floor of phase), single bank, 2-cycle latency.

Test Plan:
- Write 640 samples of ramp 0..639, pulse wr_line_start, pulse rd_line_start, h_step=0x10000, 640 rd_req cycles -> rd_data 0..639 in order, first valid 2 cycles after the first rd_req, line_len=640.
- Same line, h_step=0x8000, 1280 rd_req cycles -> each sample appears twice (0,0,1,1,...). Reads past line_len-1 hold at 639.
- Three rd_line_start pulses with no new wr_line_start -> the same line is replayed each time, rd_repeat pulses twice. Then commit line B (all 0xABC), pulse rd_line_start -> 0xABC output, no rd_repeat.
- Write 1100 samples before wr_line_start -> wr_trunc=1, line_len=1024, samples 1024..1099 absent. The flag persists after the next line; it is cleared only by rst_n low.
- wr_line_start and rd_line_start in the same cycle while writing continuously for 10 lines -> the reader always shows the just-committed line, and no output line is corrupted (per-line constant patterns read back intact).
- LINE_SCALER_INTERP_EN with samples 100,200 and h_step=0x4000 -> outputs 100,125,150,175,200; latency 3.
